quiz_arbiter: RTL and testbench

QUIZ_ARBITER -- requirements
Module: quiz_arbiter

---
 rtl/quiz_arbiter.sv | 159 +++++++++++++++
 tb/tb_quiz_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_arbiter.sv
// Quiz-show buzz-in arbiter: synchronized host/player keys, BCD countdown,
// first-key lockout with winner display and a timed buzzer pulse.
module quiz_arbiter #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int COUNT_SEC = 30,
  parameter int BEEP_CYC  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] key,
  output logic [3:0] winner_bin,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       buzzer,
  output logic [1:0] state_o
);

  // state   | meaning
  // IDLE    | waiting for host start, countdown shows COUNT_SEC
  // RUN     | countdown running, first player key wins
  // LOCK    | a player won, countdown frozen, winner shown
  // TIMEOUT | countdown reached 00 with no player key

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    LOCK    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(BEEP_CYC + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEEP_LEN  = BW'(BEEP_CYC);
  localparam logic [3:0]    INIT_TENS = 4'(COUNT_SEC / 10);
  localparam logic [3:0]    INIT_ONES = 4'(COUNT_SEC % 10);

  logic       start_m, start_s, start_d;
  logic       clear_m, clear_s;
  logic [7:0] key_m, key_s;

  state_t        state, state_nx;
  logic [TW-1:0] tick_cnt, tick_nx;
  logic [BW-1:0] beep_cnt, beep_nx;
  logic [3:0]    tens_nx, ones_nx, win_nx, key_winner;
  logic          buzz_nx;
  logic          start_rise, key_any, tick_end, last_sec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_m <= 1'b0;
      start_s <= 1'b0;
      start_d <= 1'b0;
      clear_m <= 1'b0;
      clear_s <= 1'b0;
      key_m   <= 8'h00;
      key_s   <= 8'h00;
    end else begin
      start_m <= start;
      start_s <= start_m;
      start_d <= start_s;
      clear_m <= clear;
      clear_s <= clear_m;
      key_m   <= key;
      key_s   <= key_m;
    end
  end

  assign start_rise = start_s & ~start_d;
  assign key_any    = |key_s;
  assign tick_end   = (tick_cnt == TICK_LAST);
  assign last_sec   = (cnt_tens == 4'd0) && (cnt_ones == 4'd1);

  // Lowest-numbered pressed key wins a simultaneous press.
  always_comb begin
    key_winner = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (key_s[i]) key_winner = 4'(i + 1);
    end
  end

  always_comb begin
    state_nx = state;
    tens_nx  = cnt_tens;
    ones_nx  = cnt_ones;
    tick_nx  = tick_cnt;
    win_nx   = winner_bin;
    beep_nx  = (beep_cnt != '0) ? beep_cnt - 1'b1 : beep_cnt;
    buzz_nx  = (beep_cnt != '0);
    if (clear_s) begin
      state_nx = IDLE;
      tens_nx  = INIT_TENS;
      ones_nx  = INIT_ONES;
      tick_nx  = '0;
      win_nx   = 4'hF;
      beep_nx  = '0;
      buzz_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_rise) begin
            state_nx = RUN;
            tens_nx  = INIT_TENS;
            ones_nx  = INIT_ONES;
            tick_nx  = '0;
          end
        end
        RUN: begin
          // A key on the final-tick cycle wins; the countdown stays at 01.
          if (key_any) begin
            state_nx = LOCK;
            win_nx   = key_winner;
            beep_nx  = BEEP_LEN;
          end else if (tick_end) begin
            tick_nx = '0;
            if (last_sec) begin
              ones_nx  = 4'd0;
              state_nx = TIMEOUT;
              beep_nx  = BEEP_LEN;
            end else if (cnt_ones == 4'd0) begin
              ones_nx = 4'd9;
              tens_nx = cnt_tens - 4'd1;
            end else begin
              ones_nx = cnt_ones - 4'd1;
            end
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
        LOCK, TIMEOUT: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt_tens   <= INIT_TENS;
      cnt_ones   <= INIT_ONES;
      tick_cnt   <= '0;
      winner_bin <= 4'hF;
      beep_cnt   <= '0;
      buzzer     <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt_tens   <= tens_nx;
      cnt_ones   <= ones_nx;
      tick_cnt   <= tick_nx;
      winner_bin <= win_nx;
      beep_cnt   <= beep_nx;
      buzzer     <= buzz_nx;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_quiz_arbiter.sv
// Self-checking bench for quiz_arbiter: directed scenarios plus randomized
// traffic compared against a seconds-and-timestamps reference model.
module tb_quiz_arbiter;
  localparam int TICK_DIV  = 10;
  localparam int COUNT_SEC = 3;
  localparam int BEEP_CYC  = 4;
  localparam logic [14:0] IDLE_V = {2'd0, 4'hF, 4'd0, 4'd3, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] key = 8'h00;
  logic [3:0] winner_bin, cnt_tens, cnt_ones;
  logic       buzzer;
  logic [1:0] state_o;
  logic [14:0] obs;
  int total = 0;
  int bad = 0;

  quiz_arbiter #(.TICK_DIV(TICK_DIV), .COUNT_SEC(COUNT_SEC), .BEEP_CYC(BEEP_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .key(key),
    .winner_bin(winner_bin), .cnt_tens(cnt_tens), .cnt_ones(cnt_ones),
    .buzzer(buzzer), .state_o(state_o)
  );

  always #5 clk = ~clk;
  assign obs = {state_o, winner_bin, cnt_tens, cnt_ones, buzzer};

  // Reference model: mode code, whole seconds left, cycle-stamped beep window.
  int m_mode = 0, m_sec = COUNT_SEC, m_tick = 0, m_win = 15, m_entry = 0, m_cyc = 0;
  bit m_beep_on = 0;
  logic sh1 = 0, sh2 = 0, sh3 = 0, ch1 = 0, ch2 = 0;
  logic [7:0] kh1 = 0, kh2 = 0, mk;
  logic mc, ms;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_sec = COUNT_SEC; m_tick = 0; m_win = 15;
      m_beep_on = 0; m_entry = 0; m_cyc = 0;
      sh1 = 0; sh2 = 0; sh3 = 0; ch1 = 0; ch2 = 0; kh1 = 0; kh2 = 0;
    end else begin
      m_cyc++;
      mk = kh2; mc = ch2; ms = sh2 && !sh3;
      sh3 = sh2; sh2 = sh1; sh1 = start;
      kh2 = kh1; kh1 = key; ch2 = ch1; ch1 = clear;
      if (mc) begin
        m_mode = 0; m_sec = COUNT_SEC; m_tick = 0; m_win = 15; m_beep_on = 0;
      end else if (m_mode == 0) begin
        if (ms) begin m_mode = 1; m_sec = COUNT_SEC; m_tick = 0; end
      end else if (m_mode == 1) begin
        if (mk != 0) begin
          m_mode = 2;
          for (int i = 7; i >= 0; i--) if (mk[i]) m_win = i + 1;
          m_entry = m_cyc; m_beep_on = 1;
        end else if (m_tick == TICK_DIV - 1) begin
          m_tick = 0;
          m_sec--;
          if (m_sec == 0) begin m_mode = 3; m_entry = m_cyc; m_beep_on = 1; end
        end else begin
          m_tick++;
        end
      end
    end
  end

  task automatic go_idle();
    key = 8'h00; start = 1'b0; clear = 1'b1;
    repeat (4) @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (obs !== IDLE_V) begin bad++; $display("FAIL reset_hold obs=%h want=%h", obs, IDLE_V); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (obs !== IDLE_V) begin bad++; $display("FAIL reset_release obs=%h want=%h", obs, IDLE_V); end
  endtask

  task automatic test_timeout();
    int t_run, t_to, buzz_n, first_buzz;
    logic [3:0] prev;
    int ch[$];
    go_idle();
    start = 1'b1;
    t_run = -1;
    for (int i = 0; i < 10 && t_run < 0; i++) begin
      @(negedge clk);
      if (state_o == 2'd1) t_run = i;
    end
    start = 1'b0;
    total++;
    if (t_run != 2) begin bad++; $display("FAIL start_latency got=%0d want=2", t_run); end
    total++;
    if (obs !== {2'd1, 4'hF, 4'd0, 4'd3, 1'b0}) begin
      bad++; $display("FAIL run_entry obs=%h want=%h", obs, {2'd1, 4'hF, 4'd0, 4'd3, 1'b0});
    end
    prev = cnt_ones; t_to = -1; buzz_n = 0; first_buzz = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (cnt_ones != prev) ch.push_back(c);
      prev = cnt_ones;
      if (buzzer) begin buzz_n++; if (first_buzz < 0) first_buzz = c; end
      if (state_o == 2'd3 && t_to < 0) t_to = c;
    end
    total++;
    if (ch.size() != 3 || ch[0] != 10 || ch[1] != 20 || ch[2] != 30) begin
      bad++; $display("FAIL tick_spacing n=%0d want 3 changes at 10/20/30", ch.size());
    end
    total++;
    if (t_to != 30) begin bad++; $display("FAIL timeout_cycle got=%0d want=30", t_to); end
    total++;
    if (buzz_n != BEEP_CYC || first_buzz != 31) begin
      bad++; $display("FAIL timeout_beep len=%0d first=%0d want len=4 first=31", buzz_n, first_buzz);
    end
    total++;
    if (obs !== {2'd3, 4'hF, 4'd0, 4'd0, 1'b0}) begin
      bad++; $display("FAIL timeout_final obs=%h want=%h", obs, {2'd3, 4'hF, 4'd0, 4'd0, 1'b0});
    end
  endtask

  task automatic test_lock();
    int t_lock, buzz_n;
    go_idle();
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    key = 8'h24;
    t_lock = -1; buzz_n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (state_o == 2'd2 && t_lock < 0) t_lock = c;
      if (buzzer) buzz_n++;
      if (c == 10) key = 8'h00;
    end
    total++;
    if (t_lock != 3) begin bad++; $display("FAIL key_latency got=%0d want=3", t_lock); end
    total++;
    if (obs !== {2'd2, 4'd3, 4'd0, 4'd2, 1'b0}) begin
      bad++; $display("FAIL lock_final obs=%h want=%h", obs, {2'd2, 4'd3, 4'd0, 4'd2, 1'b0});
    end
    total++;
    if (buzz_n != BEEP_CYC) begin bad++; $display("FAIL lock_beep len=%0d want=4", buzz_n); end
  endtask

  task automatic test_key_held();
    int t_run, t_lock;
    go_idle();
    key = 8'hFF;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_run = -1; t_lock = -1;
    for (int c = 1; c <= 12 && t_lock < 0; c++) begin
      @(negedge clk);
      if (state_o == 2'd1 && t_run < 0) t_run = c;
      if (state_o == 2'd2) t_lock = c;
    end
    total++;
    if (t_run < 0 || t_lock <= t_run || t_lock - t_run > 2) begin
      bad++; $display("FAIL held_key_lock run=%0d lock=%0d want lock within 2", t_run, t_lock);
    end
    total++;
    if (winner_bin !== 4'd1) begin bad++; $display("FAIL held_key_winner got=%0d want=1", winner_bin); end
    key = 8'h00;
  endtask

  task automatic test_clear_start();
    clear = 1'b1; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        total++;
        if (obs !== IDLE_V) begin bad++; $display("FAIL clear_prio c=%0d obs=%h want=%h", c, obs, IDLE_V); end
      end
    end
    clear = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (obs !== IDLE_V) begin bad++; $display("FAIL start_ignored obs=%h want=%h", obs, IDLE_V); end
    start = 1'b0;
  endtask

  task automatic test_final_tick();
    int t_run, t_lock;
    go_idle();
    start = 1'b1;
    t_run = -1;
    for (int i = 0; i < 10 && t_run < 0; i++) begin
      @(negedge clk);
      if (state_o == 2'd1) t_run = i;
    end
    start = 1'b0;
    repeat (27) @(negedge clk);
    key = 8'h10;
    t_lock = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (state_o == 2'd2 && t_lock < 0) begin
        t_lock = c;
        total++;
        if (obs !== {2'd2, 4'd5, 4'd0, 4'd1, 1'b0}) begin
          bad++; $display("FAIL final_tick_lock obs=%h want=%h", obs, {2'd2, 4'd5, 4'd0, 4'd1, 1'b0});
        end
      end
    end
    total++;
    if (t_lock != 3) begin bad++; $display("FAIL final_tick_when got=%0d want=3", t_lock); end
    key = 8'h00;
    repeat (15) @(negedge clk);
    total++;
    if (obs !== {2'd2, 4'd5, 4'd0, 4'd1, 1'b0}) begin
      bad++; $display("FAIL lock_frozen obs=%h want=%h", obs, {2'd2, 4'd5, 4'd0, 4'd1, 1'b0});
    end
  endtask

  task automatic test_rst_mid();
    go_idle();
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== IDLE_V) begin bad++; $display("FAIL rst_async obs=%h want=%h", obs, IDLE_V); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (obs !== IDLE_V) begin bad++; $display("FAIL rst_resume obs=%h want=%h", obs, IDLE_V); end
  endtask

  task automatic test_random();
    logic [14:0] expv;
    go_idle();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      expv = {2'(m_mode), 4'(m_win), 4'(m_sec / 10), 4'(m_sec % 10),
              m_beep_on && (m_cyc > m_entry) && (m_cyc <= m_entry + BEEP_CYC)};
      total++;
      if (obs !== expv) begin bad++; $display("FAIL random c=%0d obs=%h want=%h", c, obs, expv); end
      rst   = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 5) == 0);
      key   = ($urandom_range(0, 29) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    end
    rst = 1'b0; clear = 1'b0; start = 1'b0; key = 8'h00;
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_lock();
    test_key_held();
    test_clear_start();
    test_final_tick();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
